// File: rtl/wspr_input_debounce.sv
// wspr_input_debounce: synchronize an async level, debounce it with a dwell-count FSM, count rejected glitches.
module wspr_input_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter bit RESET_LEVEL     = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       din,
  output logic       sig,
  output logic       stable,
  output logic [7:0] glitch_cnt
);
  localparam int CNT_W = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  // bit 0 set marks the two qualifying states, so stable is a single flop bit
  typedef enum logic [1:0] {S_LOW = 2'b00, S_RISE = 2'b01, S_HIGH = 2'b10, S_FALL = 2'b11} state_t;
  logic [SYNC_STAGES-1:0] sync_q;
  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [7:0]             glitch_q, glitch_d, glitch_inc;
  logic                   sig_q, sig_d, ds;
  assign ds         = sync_q[SYNC_STAGES-1];
  assign glitch_inc = &glitch_q ? glitch_q : glitch_q + 8'd1;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      sync_q   <= {SYNC_STAGES{RESET_LEVEL}};
      state_q  <= RESET_LEVEL ? S_HIGH : S_LOW;
      cnt_q    <= '0;
      glitch_q <= '0;
      sig_q    <= RESET_LEVEL;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], din};
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      glitch_q <= glitch_d;
      sig_q    <= sig_d;
    end
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    glitch_d = glitch_q;
    sig_d    = sig_q;
    case (state_q)
      S_LOW:
        if (ds) begin
          state_d = S_RISE;
          cnt_d   = '0;
        end
      S_RISE:
        if (!ds) begin
          state_d  = S_LOW;
          glitch_d = glitch_inc;
        end else if (cnt_q == LAST) begin
          state_d = S_HIGH;
          sig_d   = 1'b1;
        end else cnt_d = cnt_q + CNT_W'(1);
      S_HIGH:
        if (!ds) begin
          state_d = S_FALL;
          cnt_d   = '0;
        end
      S_FALL:
        if (ds) begin
          state_d  = S_HIGH;
          glitch_d = glitch_inc;
        end else if (cnt_q == LAST) begin
          state_d = S_LOW;
          sig_d   = 1'b0;
        end else cnt_d = cnt_q + CNT_W'(1);
    endcase
  end
  assign sig        = sig_q;
  assign stable     = ~state_q[0];
  assign glitch_cnt = glitch_q;
endmodule

// File: tb/tb_wspr_input_debounce.sv
// tb_wspr_input_debounce: directed checks of latency, glitch rejection, saturation and async reset.
module tb_wspr_input_debounce;
  logic       clk = 1'b0, rst = 1'b0, din = 1'b0, din2 = 1'b1;
  logic       sig, stable, sig2, stable2;
  logic [7:0] glitch_cnt, glitch_cnt2;
  int         tests = 0, fails = 0;
  always #5 clk = ~clk;
  wspr_input_debounce #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .RESET_LEVEL(1'b0)) dut (
    .clk(clk), .rst(rst), .din(din), .sig(sig), .stable(stable), .glitch_cnt(glitch_cnt));
  wspr_input_debounce #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(1), .RESET_LEVEL(1'b1)) dut2 (
    .clk(clk), .rst(rst), .din(din2), .sig(sig2), .stable(stable2), .glitch_cnt(glitch_cnt2));
  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic do_reset(input logic d, input logic d2);
    @(posedge clk);
    #2 rst = 1'b0;
    din = d;
    din2 = d2;
    #10 rst = 1'b1;
    #1;
  endtask
  task automatic test_reset;
    @(posedge clk);
    #2 rst = 1'b0;
    din = 1'b0;
    #1;
    tests++;
    if (sig !== 1'b0 || stable !== 1'b1 || glitch_cnt !== 8'd0) begin
      fails++;
      $display("FAIL reset_async: sig=%b stable=%b glitch=%0d, want 0 1 0", sig, stable, glitch_cnt);
    end
    #10 rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      edges(1);
      tests++;
      if (sig !== 1'b0 || stable !== 1'b1 || glitch_cnt !== 8'd0) begin
        fails++;
        $display("FAIL reset_hold[%0d]: sig=%b stable=%b glitch=%0d, want 0 1 0", i, sig, stable, glitch_cnt);
      end
    end
  endtask
  task automatic test_latency;
    do_reset(1'b0, 1'b1);
    edges(2);
    for (int dir = 0; dir < 2; dir++) begin
      din = (dir == 0);
      for (int e = 1; e <= 7; e++) begin
        edges(1);
        tests++;
        if (sig !== ((e >= 7) ~^ (dir == 0)) || stable !== !(e >= 3 && e <= 6)) begin
          fails++;
          $display("FAIL latency dir=%0d edge=%0d: sig=%b stable=%b, want %b %b",
                   dir, e, sig, stable, (e >= 7) ~^ (dir == 0), !(e >= 3 && e <= 6));
        end
      end
    end
  endtask
  task automatic test_glitch_saturate;
    do_reset(1'b0, 1'b1);
    edges(2);
    for (int i = 0; i < 300; i++) begin
      din = 1'b1;
      edges(3);
      din = 1'b0;
      edges(3);
      tests++;
      if (sig !== 1'b0 || glitch_cnt !== ((i + 1 > 255) ? 8'd255 : 8'(i + 1))) begin
        fails++;
        $display("FAIL glitch_sat[%0d]: sig=%b glitch=%0d, want 0 %0d", i, sig, glitch_cnt, (i + 1 > 255) ? 255 : i + 1);
      end
    end
  endtask
  task automatic test_fall_glitch;
    do_reset(1'b0, 1'b1);
    din = 1'b1;
    edges(9);
    tests++;
    if (sig !== 1'b1 || stable !== 1'b1 || glitch_cnt !== 8'd0) begin
      fails++;
      $display("FAIL fall_glitch_setup: sig=%b stable=%b glitch=%0d, want 1 1 0", sig, stable, glitch_cnt);
    end
    din = 1'b0;
    edges(2);
    din = 1'b1;
    edges(5);
    tests++;
    if (sig !== 1'b1 || stable !== 1'b1 || glitch_cnt !== 8'd1) begin
      fails++;
      $display("FAIL fall_glitch_reject: sig=%b stable=%b glitch=%0d, want 1 1 1", sig, stable, glitch_cnt);
    end
    din = 1'b0;
    edges(6);
    tests++;
    if (sig !== 1'b1 || stable !== 1'b0) begin
      fails++;
      $display("FAIL fall_clean_e6: sig=%b stable=%b, want 1 0", sig, stable);
    end
    edges(1);
    tests++;
    if (sig !== 1'b0 || stable !== 1'b1 || glitch_cnt !== 8'd1) begin
      fails++;
      $display("FAIL fall_clean_e7: sig=%b stable=%b glitch=%0d, want 0 1 1", sig, stable, glitch_cnt);
    end
  endtask
  task automatic test_reset_mid_check;
    do_reset(1'b0, 1'b1);
    edges(2);
    din = 1'b1;
    edges(4);
    tests++;
    if (stable !== 1'b0 || sig !== 1'b0) begin
      fails++;
      $display("FAIL midcheck_rise: sig=%b stable=%b, want 0 0", sig, stable);
    end
    #2 rst = 1'b0;
    #1;
    tests++;
    if (sig !== 1'b0 || stable !== 1'b1 || glitch_cnt !== 8'd0) begin
      fails++;
      $display("FAIL midcheck_async: sig=%b stable=%b glitch=%0d, want 0 1 0", sig, stable, glitch_cnt);
    end
    #10 rst = 1'b1;
    edges(6);
    tests++;
    if (sig !== 1'b0) begin
      fails++;
      $display("FAIL midcheck_e6: sig=%b, want 0", sig);
    end
    edges(1);
    tests++;
    if (sig !== 1'b1 || glitch_cnt !== 8'd0) begin
      fails++;
      $display("FAIL midcheck_e7: sig=%b glitch=%0d, want 1 0", sig, glitch_cnt);
    end
  endtask
  task automatic test_level1_d1;
    do_reset(1'b0, 1'b1);
    tests++;
    if (sig2 !== 1'b1 || stable2 !== 1'b1 || glitch_cnt2 !== 8'd0) begin
      fails++;
      $display("FAIL d1_reset: sig=%b stable=%b glitch=%0d, want 1 1 0", sig2, stable2, glitch_cnt2);
    end
    edges(3);
    din2 = 1'b0;
    edges(1);
    din2 = 1'b1;
    edges(4);
    tests++;
    if (sig2 !== 1'b1 || stable2 !== 1'b1 || glitch_cnt2 !== 8'd1) begin
      fails++;
      $display("FAIL d1_glitch: sig=%b stable=%b glitch=%0d, want 1 1 1", sig2, stable2, glitch_cnt2);
    end
    din2 = 1'b0;
    edges(3);
    tests++;
    if (sig2 !== 1'b1 || stable2 !== 1'b0) begin
      fails++;
      $display("FAIL d1_fall_e3: sig=%b stable=%b, want 1 0", sig2, stable2);
    end
    edges(1);
    tests++;
    if (sig2 !== 1'b0 || stable2 !== 1'b1 || glitch_cnt2 !== 8'd1) begin
      fails++;
      $display("FAIL d1_fall_e4: sig=%b stable=%b glitch=%0d, want 0 1 1", sig2, stable2, glitch_cnt2);
    end
  endtask
  initial begin
    test_reset;
    test_latency;
    test_glitch_saturate;
    test_fall_glitch;
    test_reset_mid_check;
    test_level1_d1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/wspr_input_debounce.md
Name: wspr_input_debounce

Overview:
Conditions one asynchronous external level, such as the GPS 1PPS line or the transmit-start switch, into a clean, clk-synchronous level. The output drives the rising-edge pulse generator directly downstream, which requires its input to be synchronous to clk and free of glitches. The block has three stages in series: a multi-flop synchronizer, a 4-state debounce FSM with a dwell counter, and a saturating count of rejected glitches for status readback.

Parameters:
SYNC_STAGES, 2, number of synchronizer flops; legal range 2..4.
DEBOUNCE_CYCLES, 1000, consecutive clk cycles of stable synchronized input needed to accept a change; minimum 1.
RESET_LEVEL, 0, value of the synchronizer flops and of sig during and after reset.
CNT_W, derived as max(1, clog2(DEBOUNCE_CYCLES)), width of the dwell counter; not user-set.

Ports:
clk  input  1  system clock; the only clock in the block.
rst  input  1  asynchronous, active-low reset.
din  input  1  raw asynchronous input level.
sig  output 1  debounced level, registered and synchronous to clk; feeds the pulse generator.
stable  output 1  1 when the FSM is in S_LOW or S_HIGH; 0 while a change is being qualified.
glitch_cnt  output 8  saturating count of rejected transitions.

Behaviour:
- Reset (rst=0, asynchronous):
  - All synchronizer flops take RESET_LEVEL.
  - FSM enters S_HIGH if RESET_LEVEL=1, else S_LOW.
  - Dwell counter is cleared to 0.
  - sig=RESET_LEVEL, stable=1, glitch_cnt=0.
  - All state is held while rst=0; normal operation starts on the first clk edge after deassertion.
- Synchronizer:
  - din passes through SYNC_STAGES flops in series.
  - ds is the last flop. Only ds is used by the FSM; din is never used combinationally.
- FSM (all transitions on the rising edge of clk):
  - S_LOW (sig=0):
    - ds=1: go to S_RISE, clear counter.
    - ds=0: stay.
  - S_RISE (sig=0):
    - ds=0: return to S_LOW, increment glitch_cnt.
    - ds=1 and counter=DEBOUNCE_CYCLES-1: go to S_HIGH, set sig=1.
    - ds=1 otherwise: increment counter.
  - S_HIGH (sig=1):
    - ds=0: go to S_FALL, clear counter.
    - ds=1: stay.
  - S_FALL (sig=1): mirror of S_RISE with polarity swapped.
    - ds=1: return to S_HIGH, increment glitch_cnt.
    - ds=0 and counter=DEBOUNCE_CYCLES-1: go to S_LOW, set sig=0.
    - ds=0 otherwise: increment counter.
- Acceptance condition: ds must hold its new value on DEBOUNCE_CYCLES+1 consecutive sampling edges, counting the edge that enters S_RISE or S_FALL.
- Latency:
  - Count from the first clk edge that samples the new din value.
  - sig changes after SYNC_STAGES+1+DEBOUNCE_CYCLES edges; 7 edges for S=2, D=4.
  - Both edge directions have the same latency.
- A glitch aborts the check immediately. No partial credit carries over: the next attempt restarts the counter at 0.
- glitch_cnt:
  - Increments by exactly 1 per aborted check.
  - Holds at 255 once saturated.
  - Cleared only by reset.
- sig changes only on the clk edge that enters S_HIGH or S_LOW, so it is glitch-free for downstream logic.
- stable=0 exactly while the FSM is in S_RISE or S_FALL.
- Reset asserted mid-check: the check is discarded and sig returns to RESET_LEVEL asynchronously. glitch_cnt does not increment.
- If din differs from RESET_LEVEL when reset is released, a normal full check runs. There is no shortcut.
- DEBOUNCE_CYCLES=1: the counter is never incremented; acceptance occurs on the edge after entry if ds still holds.
- Counter width and FSM logic must stay correct for any legal DEBOUNCE_CYCLES, including values that are not a power of 2.

Test Plan:
(All scenarios use SYNC_STAGES=2, DEBOUNCE_CYCLES=4, RESET_LEVEL=0 unless stated.)
1. Reset with din=0, release, hold 20 cycles -> sig=0, stable=1, glitch_cnt=0 throughout.
2. din 0->1 and held -> stable=0 from edge 3 to edge 6; sig=1 and stable=1 after edge 7. Then din 1->0 -> sig=0 after 7 more edges.
3. din high for 3 cycles, then low; repeat 300 times -> sig stays 0, glitch_cnt increments to 255 and holds there.
4. din pulses low for 2 cycles while sig=1 -> FSM returns to S_HIGH, sig stays 1, glitch_cnt +1. A later clean fall is still accepted after 7 edges.
5. rst asserted asynchronously, between clk edges, during S_RISE -> sig=0 and stable=1 at once with no clk edge needed. After release with din=1 -> sig=1 after exactly 7 edges.
6. RESET_LEVEL=1 and DEBOUNCE_CYCLES=1, din held 1 -> sig=1 out of reset. din low for 1 cycle -> rejected, glitch_cnt=1. din low and held -> sig=0 after 4 edges.
